mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RAMSIZE, default 64, meaning number of 8-bit RAM words owned by the arbiter.
REQ-002 Parameter AW, default 8, meaning address width of every port.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req[2:0]  input  3  per-port access request; port 0 = loader, port 1 = fetch, port 2 = data.
REQ-006 we[2:0]  input  3  per-port write enable; 1 = write, 0 = read.
REQ-007 addr0/addr1/addr2  input  AW each  per-port byte address.
REQ-008 wdata0/wdata1/wdata2  input  8 each  per-port write data.
REQ-009 lock  input  1  while high, only port 0 is eligible for a grant.
REQ-010 gnt[2:0]  output  3  registered one-hot grant; at most one bit high.
REQ-011 rvalid[2:0]  output  3  registered one-hot read-data-valid pulse.
REQ-012 rdata  output  8  read data shared by all ports; qualified by rvalid.
REQ-013 err  output  1  one-cycle pulse flagging an out-of-range access.
REQ-014 busy  output  1  high while the FSM is in GRANT.

Function
REQ-015 The FSM SHALL have two states: IDLE and GRANT.
REQ-016 IDLE: if any eligible req is high, select a winner, latch its we/addr/wdata, set gnt[winner], go to GRANT; otherwise stay in IDLE with gnt=0.
REQ-017 GRANT: perform the latched access at the clock edge ending the state, clear gnt, return to IDLE; new reqs are not sampled in GRANT.
REQ-018 Throughput is one access per two cycles; back-to-back grants to different ports are legal.
REQ-019 Port 0 SHALL have fixed highest priority over ports 1 and 2.
REQ-020 Ports 1 and 2 SHALL be round-robin: a pointer records the last of them granted, and when both request, the other port wins.
REQ-021 A port 0 grant SHALL NOT update the round-robin pointer.
REQ-022 When lock is high in IDLE, req[1] and req[2] are ignored and stay pending; lock has no effect on an access already in GRANT.
REQ-023 A requester SHALL hold req/we/addr/wdata stable until it sees its gnt bit; it drops req in that same cycle or is granted again.
REQ-024 Write: ram[addr] <= wdata at the end of GRANT; rvalid stays 0.
REQ-025 Read: rdata <= ram[addr] and rvalid[winner] <= 1 at the end of GRANT, so rvalid is high the cycle after gnt and lasts one cycle.
REQ-026 rdata SHALL hold its last value when rvalid is 0.
REQ-027 Address >= RAMSIZE: a write is discarded; a read returns rdata=0 with rvalid still pulsed; err pulses in the same cycle rvalid would.
REQ-028 A simultaneous write and read of the same address by consecutive grants SHALL return the new data, as the write completes first.

Reset
REQ-029 On reset assertion, immediately: state=IDLE, gnt=0, rvalid=0, rdata=0, err=0, busy=0, round-robin pointer=2 (port 1 preferred next).
REQ-030 Reset during GRANT SHALL abort the access; the RAM is not written and no rvalid is issued.
REQ-031 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-032 Port 0 writes 0x2A to addr 5, then port 1 reads addr 5 -> gnt[0] for 1 cycle, then gnt[1], rvalid[1] the next cycle with rdata=0x2A.
REQ-033 req=3'b111 held, each port dropping req on its grant -> grant order 0, 1, 2.
REQ-034 Ports 1 and 2 request continuously for 4 grants -> order 1, 2, 1, 2.
REQ-035 lock=1 with req=3'b110 for 6 cycles -> no grant; lock=0 -> gnt[1] on the next IDLE cycle.
REQ-036 Port 2 reads addr 64 -> rvalid[2]=1, rdata=0, err=1 in the same cycle; port 2 then writes 0x55 to addr 70 -> no RAM location changes.
REQ-037 reset pulsed while in GRANT on a write of 0x77 to addr 3 -> ram[3] is unchanged, all outputs are 0, and the next grant is to port 1 if ports 1 and 2 both request.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Three-port arbiter in front of a small byte-wide RAM. Port 0
//                has fixed priority; ports 1 and 2 share by round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int RAMSIZE = 64,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [7:0]    wdata0,
    input  logic [7:0]    wdata1,
    input  logic [7:0]    wdata2,
    input  logic          lock,
    output logic [2:0]    gnt,
    output logic [2:0]    rvalid,
    output logic [7:0]    rdata,
    output logic          err,
    output logic          busy
);

    localparam int c_IDX_W = (RAMSIZE > 1) ? $clog2(RAMSIZE) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_grant;
    logic [1:0]      w_winner;
    logic [2:0]      w_elig;
    logic [AW-1:0]   w_sel_addr;
    logic [7:0]      w_sel_wdata;
    logic            w_sel_we;
    logic            w_oob;
    logic [c_IDX_W-1:0] w_idx;

    logic [1:0]      r_rr_last;
    logic [1:0]      r_port;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_wdata;
    logic [7:0]      r_ram [RAMSIZE];

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_winner     = 2'd0;
        w_elig       = lock ? (req & 3'b001) : req;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_grant      = 1'b1;
                    w_state_next = S_GRANT;
                    if (w_elig[0])
                        w_winner = 2'd0;
                    else if (w_elig[1] && w_elig[2])
                        w_winner = (r_rr_last == 2'd1) ? 2'd2 : 2'd1;
                    else if (w_elig[1])
                        w_winner = 2'd1;
                    else
                        w_winner = 2'd2;
                end
            end
            S_GRANT: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_addr  = addr0;
        w_sel_wdata = wdata0;
        w_sel_we    = we[0];
        case (w_winner)
            2'd1: begin
                w_sel_addr  = addr1;
                w_sel_wdata = wdata1;
                w_sel_we    = we[1];
            end
            2'd2: begin
                w_sel_addr  = addr2;
                w_sel_wdata = wdata2;
                w_sel_we    = we[2];
            end
            default: ;
        endcase
    end

    assign w_oob = (32'(r_addr) >= 32'(RAMSIZE));
    assign w_idx = r_addr[c_IDX_W-1:0];
    assign busy  = (r_state == S_GRANT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            gnt       <= 3'b000;
            rvalid    <= 3'b000;
            rdata     <= 8'h00;
            err       <= 1'b0;
            r_rr_last <= 2'd2;
            r_port    <= 2'd0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 8'h00;
        end else begin
            r_state <= w_state_next;
            rvalid  <= 3'b000;
            err     <= 1'b0;
            gnt     <= w_grant ? (3'b001 << w_winner) : 3'b000;
            if (w_grant) begin
                r_port  <= w_winner;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                // Port 0 grants leave the round-robin history untouched
                if (w_winner != 2'd0)
                    r_rr_last <= w_winner;
            end
            if (r_state == S_GRANT) begin
                err <= w_oob;
                if (!r_we) begin
                    rvalid <= 3'b001 << r_port;
                    rdata  <= w_oob ? 8'h00 : r_ram[w_idx];
                end
            end
        end
    end

    // Reset forces IDLE asynchronously, so an aborted GRANT never writes
    always_ff @(posedge clk) begin
        if (r_state == S_GRANT && r_we && !w_oob)
            r_ram[w_idx] <= r_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req, we;
    logic [7:0] addr0, addr1, addr2;
    logic [7:0] wdata0, wdata1, wdata2;
    logic       lock;
    logic [2:0] gnt, rvalid;
    logic [7:0] rdata;
    logic       err, busy;

    int checks   = 0;
    int failures = 0;
    int order[$];

    mem_arbiter #(.RAMSIZE(64), .AW(8)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: one pending access at a time, performed the cycle after its grant
    logic [2:0] e_gnt = 3'b000, e_rvalid = 3'b000;
    logic       e_err = 1'b0, e_busy = 1'b0;
    logic [7:0] e_rdata = 8'h00;
    bit         e_rdk = 1'b1;
    int         last12 = 2;
    bit         pend = 1'b0;
    int         p_port, p_addr;
    bit         p_we;
    logic [7:0] p_wd;
    logic [7:0] m_mem [64];
    bit         m_known [64];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_gnt = 0; e_rvalid = 0; e_err = 0; e_busy = 0;
            e_rdata = 0; e_rdk = 1; last12 = 2; pend = 0;
        end else begin
            e_rvalid = 0;
            e_err    = 0;
            e_gnt    = 0;
            if (pend) begin
                if (p_addr >= 64) begin
                    e_err = 1;
                    if (!p_we) begin
                        e_rvalid[p_port] = 1'b1;
                        e_rdata = 0;
                        e_rdk = 1;
                    end
                end else if (p_we) begin
                    m_mem[p_addr]   = p_wd;
                    m_known[p_addr] = 1'b1;
                end else begin
                    e_rvalid[p_port] = 1'b1;
                    e_rdata = m_mem[p_addr];
                    e_rdk   = m_known[p_addr];
                end
                pend = 0;
            end else begin
                bit c0, c1, c2;
                int w;
                c0 = req[0];
                c1 = req[1] && !lock;
                c2 = req[2] && !lock;
                w  = -1;
                if (c0)            w = 0;
                else if (c1 && c2) w = (last12 == 1) ? 2 : 1;
                else if (c1)       w = 1;
                else if (c2)       w = 2;
                if (w >= 0) begin
                    if (w != 0) last12 = w;
                    p_port = w;
                    p_we   = we[w];
                    p_addr = (w == 0) ? int'(addr0) : (w == 1) ? int'(addr1) : int'(addr2);
                    p_wd   = (w == 0) ? wdata0 : (w == 1) ? wdata1 : wdata2;
                    e_gnt  = 3'b001 << w;
                    pend   = 1;
                end
            end
            e_busy = pend;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (gnt !== e_gnt || rvalid !== e_rvalid || err !== e_err || busy !== e_busy ||
            (e_rdk && rdata !== e_rdata)) begin
            failures++;
            $display("FAIL model t=%0t gnt=%b/%b rvalid=%b/%b err=%b/%b busy=%b/%b rdata=%h/%h (actual/required)",
                     $time, gnt, e_gnt, rvalid, e_rvalid, err, e_err, busy, e_busy, rdata, e_rdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        we[p] = w;
        case (p)
            0: begin addr0 = a; wdata0 = d; end
            1: begin addr1 = a; wdata1 = d; end
            default: begin addr2 = a; wdata2 = d; end
        endcase
    endtask

    task automatic access(input int p, input logic w, input logic [7:0] a, input logic [7:0] d,
                          output logic [2:0] g);
        bit got = 1'b0;
        g = 3'b000;
        set_port(p, w, a, d);
        req[p] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (gnt[p]) begin
                got = 1'b1;
                g = gnt;
                req[p] = 1'b0;
            end
        end
        if (!got) begin
            req[p] = 1'b0;
            checks++;
            failures++;
            $display("FAIL access_timeout port=%0d actual=nogrant required=grant", p);
        end
    endtask

    // Collects grant order; drop=1 releases each port on its grant
    task automatic run(input int ngr, input bit drop);
        order.delete();
        for (int c = 0; c < 200 && order.size() < ngr; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (gnt[i]) begin
                    order.push_back(i);
                    if (drop) req[i] = 1'b0;
                end
        end
        if (order.size() < ngr) begin
            checks++;
            failures++;
            $display("FAIL run_timeout actual=%0d required=%0d grants", order.size(), ngr);
            for (int i = order.size(); i < ngr; i++) order.push_back(-1);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] g;
        int ng;
        reset = 1'b1; req = 0; we = 0; lock = 0;
        addr0 = 0; addr1 = 0; addr2 = 0; wdata0 = 0; wdata1 = 0; wdata2 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_outputs", {17'd0, gnt, rvalid, rdata, err, busy}, 32'd0);

        // All three request: fixed priority then round-robin from reset pointer
        set_port(0, 0, 5, 0); set_port(1, 0, 5, 0); set_port(2, 0, 5, 0);
        req = 3'b111;
        run(3, 1'b1);
        check("order3_0", order[0], 0);
        check("order3_1", order[1], 1);
        check("order3_2", order[2], 2);
        step();

        // Ports 1 and 2 continuously requesting alternate
        set_port(1, 0, 5, 0); set_port(2, 0, 5, 0);
        req = 3'b110;
        run(4, 1'b0);
        req = 3'b000;
        check("rr_0", order[0], 1);
        check("rr_1", order[1], 2);
        check("rr_2", order[2], 1);
        check("rr_3", order[3], 2);
        step();

        // Lock holds off ports 1 and 2
        lock = 1'b1;
        req  = 3'b110;
        ng   = 0;
        repeat (6) begin
            step();
            if (gnt != 0) ng++;
        end
        check("lock_no_grant", ng, 0);
        lock = 1'b0;
        step();
        check("lock_release_gnt", gnt, 3'b010);
        req[1] = 1'b0;
        run(1, 1'b1);
        check("lock_then_port2", order[0], 2);
        step();

        // Write 0x2A to 5 via port 0, read back via port 1
        access(0, 1, 5, 8'h2A, g);
        check("wr_gnt0", g, 3'b001);
        access(1, 0, 5, 8'h00, g);
        check("rd_gnt1", g, 3'b010);
        step();
        check("rd_rvalid1", rvalid, 3'b010);
        check("rd_rdata", rdata, 8'h2A);

        // Out-of-range accesses
        access(0, 1, 6, 8'h33, g);
        access(2, 0, 64, 8'h00, g);
        step();
        check("oob_rvalid2", rvalid, 3'b100);
        check("oob_rdata", rdata, 8'h00);
        check("oob_err", err, 1'b1);
        access(2, 1, 70, 8'h55, g);
        access(1, 0, 6, 8'h00, g);
        step();
        check("oob_wr_discarded", rdata, 8'h33);
        access(1, 0, 5, 8'h00, g);
        step();
        check("addr5_intact", rdata, 8'h2A);

        // Reset during a write GRANT aborts it
        access(0, 1, 3, 8'h11, g);
        access(0, 1, 3, 8'h77, g);
        #2 reset = 1'b1;
        #1 check("reset_in_grant", {17'd0, gnt, rvalid, rdata, err, busy}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        set_port(1, 0, 3, 0); set_port(2, 0, 3, 0);
        req = 3'b110;
        run(2, 1'b1);
        check("post_reset_first", order[0], 1);
        check("post_reset_second", order[1], 2);
        step();
        check("post_reset_rvalid2", rvalid, 3'b100);
        check("ram3_unchanged", rdata, 8'h11);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
